// File: rtl/alu_sequencer_if.sv
// Bus between the control unit, the alu_sequencer and the 32-bit alu.
// The slave side is the sequencer; the master side is whatever drives requests and hosts the alu.
interface alu_sequencer_if #(
    parameter int BITS      = 32,
    parameter int SIG_COUNT = 12
);
    logic                   start;
    logic [3:0]             op;
    logic [BITS-1:0]        a_in;
    logic [BITS-1:0]        b_in;
    logic [2*BITS-1:0]      alu_result;
    logic [SIG_COUNT-1:0]   alu_ctrl;
    logic [BITS-1:0]        alu_x;
    logic [BITS-1:0]        alu_y;
    logic [BITS-1:0]        z_hi;
    logic [BITS-1:0]        z_lo;
    logic [BITS-1:0]        rz_out;
    logic                   rz_we;
    logic                   lo_we;
    logic                   hi_we;
    logic                   busy;
    logic                   done;
    logic                   err;

    modport slave (
        input  start, op, a_in, b_in, alu_result,
        output alu_ctrl, alu_x, alu_y, z_hi, z_lo, rz_out,
               rz_we, lo_we, hi_we, busy, done, err
    );

    modport master (
        output start, op, a_in, b_in, alu_result,
        input  alu_ctrl, alu_x, alu_y, z_hi, z_lo, rz_out,
               rz_we, lo_we, hi_we, busy, done, err
    );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer in front of the alu: latches operands, drives the one-hot
// control for one or more EXEC cycles, captures the 64-bit Z result and strobes writeback.
module alu_sequencer #(
    parameter int BITS        = 32,
    parameter int SIG_COUNT   = 12,
    parameter int MULDIV_WAIT = 2
) (
    input  logic               clk,
    input  logic               clr,
    alu_sequencer_if.slave     bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EXEC  = 3'd1,
        WB_LO = 3'd2,
        WB_HI = 3'd3,
        ERR   = 3'd4
    } state_t;

    localparam int CNT_W = (MULDIV_WAIT < 1) ? 1 : $clog2(MULDIV_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MULDIV_WAIT);
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_LAST = 4'd11;

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          op_reg;
    logic [BITS-1:0]     x_reg;
    logic [BITS-1:0]     y_reg;
    logic [BITS-1:0]     z_hi_reg;
    logic [BITS-1:0]     z_lo_reg;
    logic [CNT_W-1:0]    wait_cnt;
    logic                is_muldiv;
    logic                exec_final;

    function automatic logic [SIG_COUNT-1:0] onehot(input logic [3:0] code);
        logic [SIG_COUNT-1:0] vec;
        vec = '0;
        for (int i = 0; i < SIG_COUNT; i++) begin
            vec[i] = (int'(code) == i);
        end
        return vec;
    endfunction

    assign is_muldiv  = (op_reg == OP_MUL) || (op_reg == OP_DIV);
    // Single-word ops finish EXEC at once; MUL/DIV stay until the counter reaches MULDIV_WAIT.
    assign exec_final = !is_muldiv || (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wait_cnt <= '0;
        end else if (state == EXEC && !exec_final) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            op_reg <= '0;
            x_reg  <= '0;
            y_reg  <= '0;
        end else if (state == IDLE && bus.start) begin
            op_reg <= bus.op;
            x_reg  <= bus.a_in;
            y_reg  <= bus.b_in;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            z_hi_reg <= '0;
            z_lo_reg <= '0;
        end else if (state == EXEC && exec_final) begin
            z_hi_reg <= bus.alu_result[2*BITS-1:BITS];
            z_lo_reg <= bus.alu_result[BITS-1:0];
        end
    end

    // Strobes are decoded from state only, so an asynchronous clear drops them at once.
    always_comb begin
        state_nxt    = state;
        bus.alu_ctrl = '0;
        bus.rz_we    = 1'b0;
        bus.lo_we    = 1'b0;
        bus.hi_we    = 1'b0;
        bus.done     = 1'b0;
        bus.err      = 1'b0;
        bus.busy     = 1'b1;
        case (state)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) begin
                    state_nxt = (bus.op > OP_LAST) ? ERR : EXEC;
                end
            end
            EXEC: begin
                bus.alu_ctrl = onehot(op_reg);
                if (exec_final) begin
                    state_nxt = WB_LO;
                end
            end
            WB_LO: begin
                if (is_muldiv) begin
                    bus.lo_we = 1'b1;
                    state_nxt = WB_HI;
                end else begin
                    bus.rz_we = 1'b1;
                    bus.done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WB_HI: begin
                bus.hi_we = 1'b1;
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            ERR: begin
                bus.err   = 1'b1;
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                bus.busy  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.alu_x  = x_reg;
    assign bus.alu_y  = y_reg;
    assign bus.z_hi   = z_hi_reg;
    assign bus.z_lo   = z_lo_reg;
    assign bus.rz_out = z_lo_reg;
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: a small behavioural alu closes the loop,
// a vector table covers every op and illegal codes, hand sequences cover held start and mid-op clear.
module tb_alu_sequencer;
    localparam int BITS = 32;
    localparam int SIGS = 12;
    localparam int W    = 2;
    localparam int K_SINGLE = 0;
    localparam int K_MULDIV = 1;
    localparam int K_ILL    = 2;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          kind;
        logic [11:0] ctrl;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    logic clk;
    logic clr;
    int   passed;
    int   total;
    logic [31:0] last_lo;
    logic [31:0] last_hi;
    vec_t vecs[$];

    alu_sequencer_if #(.BITS(BITS), .SIG_COUNT(SIGS)) bus ();

    alu_sequencer #(.BITS(BITS), .SIG_COUNT(SIGS), .MULDIV_WAIT(W)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural alu: low half = result/product-low/quotient, high half = product-high/remainder.
    logic [63:0]        alu_res;
    logic [63:0]        dbl;
    logic signed [63:0] xs;
    logic signed [63:0] ys;
    logic signed [31:0] q;
    logic signed [31:0] r;
    always_comb begin
        alu_res = '0;
        dbl     = '0;
        xs      = {{32{bus.alu_x[31]}}, bus.alu_x};
        ys      = {{32{bus.alu_y[31]}}, bus.alu_y};
        q       = '0;
        r       = '0;
        case (bus.alu_ctrl)
            12'h001: alu_res = {32'h0, bus.alu_x + bus.alu_y};
            12'h002: alu_res = {32'h0, bus.alu_x - bus.alu_y};
            12'h004: alu_res = xs * ys;
            12'h008: begin
                if (bus.alu_y != 32'h0) begin
                    q = $signed(bus.alu_x) / $signed(bus.alu_y);
                    r = $signed(bus.alu_x) % $signed(bus.alu_y);
                end
                alu_res = {r, q};
            end
            12'h010: alu_res = {32'h0, bus.alu_x >> bus.alu_y[4:0]};
            12'h020: alu_res = {32'h0, bus.alu_x << bus.alu_y[4:0]};
            12'h040: begin
                dbl     = {bus.alu_x, bus.alu_x} >> bus.alu_y[4:0];
                alu_res = {32'h0, dbl[31:0]};
            end
            12'h080: begin
                dbl     = {bus.alu_x, bus.alu_x} << bus.alu_y[4:0];
                alu_res = {32'h0, dbl[63:32]};
            end
            12'h100: alu_res = {32'h0, bus.alu_x & bus.alu_y};
            12'h200: alu_res = {32'h0, bus.alu_x | bus.alu_y};
            12'h400: alu_res = {32'h0, -bus.alu_x};
            12'h800: alu_res = {32'h0, ~bus.alu_x};
            default: alu_res = '0;
        endcase
    end
    assign bus.alu_result = alu_res;

    function automatic vec_t mk(input string name, input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, input int kind, input logic [11:0] ctrl,
                                input logic [31:0] lo, input logic [31:0] hi);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b;
        v.kind = kind; v.ctrl = ctrl; v.lo = lo; v.hi = hi;
        return v;
    endfunction

    // Expected {alu_ctrl, rz_we, lo_we, hi_we, done, err, busy} in request cycle c (1..done cycle).
    function automatic logic [17:0] exp_flags(input int kind, input int c, input logic [11:0] ctrl);
        logic [11:0] ac;
        logic rz, lo, hi, dn, er;
        ac = '0; rz = 0; lo = 0; hi = 0; dn = 0; er = 0;
        if (kind == K_SINGLE) begin
            if (c == 1) ac = ctrl;
            if (c == 2) begin rz = 1; dn = 1; end
        end else if (kind == K_MULDIV) begin
            if (c <= 1 + W) ac = ctrl;
            if (c == 2 + W) lo = 1;
            if (c == 3 + W) begin hi = 1; dn = 1; end
        end else begin
            er = 1; dn = 1;
        end
        return {ac, rz, lo, hi, dn, er, 1'b1};
    endfunction

    function automatic logic [17:0] act_flags();
        return {bus.alu_ctrl, bus.rz_we, bus.lo_we, bus.hi_we, bus.done, bus.err, bus.busy};
    endfunction

    function automatic logic [177:0] all_outs();
        return {bus.alu_ctrl, bus.alu_x, bus.alu_y, bus.z_hi, bus.z_lo, bus.rz_out,
                bus.rz_we, bus.lo_we, bus.hi_we, bus.busy, bus.done, bus.err};
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic run_vec(input vec_t v);
        int done_c;
        int lo_c;
        done_c = (v.kind == K_SINGLE) ? 2 : (v.kind == K_MULDIV) ? 3 + W : 1;
        lo_c   = (v.kind == K_SINGLE) ? 2 : 2 + W;
        @(negedge clk);
        bus.start = 1'b1; bus.op = v.op; bus.a_in = v.a; bus.b_in = v.b;
        for (int c = 1; c <= done_c; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            check($sformatf("%s c%0d flags", v.name, c), 256'(act_flags()), 256'(exp_flags(v.kind, c, v.ctrl)));
            if (v.kind == K_ILL) begin
                check($sformatf("%s z unchanged", v.name), {bus.z_hi, bus.z_lo}, {last_hi, last_lo});
            end else begin
                if (c == lo_c) begin
                    check($sformatf("%s rz_out", v.name), 256'(bus.rz_out), 256'(v.lo));
                    check($sformatf("%s z_lo", v.name), 256'(bus.z_lo), 256'(v.lo));
                end
                if (c == done_c) check($sformatf("%s z_hi", v.name), 256'(bus.z_hi), 256'(v.hi));
            end
        end
        @(negedge clk);
        check($sformatf("%s idle after", v.name), 256'(act_flags()), 256'(18'h0));
        if (v.kind != K_ILL) begin
            last_lo = v.lo;
            last_hi = v.hi;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        passed = 0; total = 0; last_lo = '0; last_hi = '0;
        clr = 1'b1; bus.start = 1'b0; bus.op = '0; bus.a_in = '0; bus.b_in = '0;

        vecs.push_back(mk("ADD",   4'd0,  32'd15,        32'd5,         K_SINGLE, 12'h001, 32'd20,        32'h0));
        vecs.push_back(mk("SUB",   4'd1,  32'd15,        32'd5,         K_SINGLE, 12'h002, 32'd10,        32'h0));
        vecs.push_back(mk("MUL",   4'd2,  32'hFFFFFFF1,  32'd5,         K_MULDIV, 12'h004, 32'hFFFFFFB5,  32'hFFFFFFFF));
        vecs.push_back(mk("ILL13", 4'd13, 32'd7,         32'd9,         K_ILL,    12'h000, 32'h0,         32'h0));
        vecs.push_back(mk("ROL",   4'd7,  32'h80000000,  32'd2,         K_SINGLE, 12'h080, 32'h00000002,  32'h0));
        vecs.push_back(mk("DIV",   4'd3,  32'd17,        32'hFFFFFFFB,  K_MULDIV, 12'h008, 32'hFFFFFFFD,  32'd2));
        vecs.push_back(mk("SHR",   4'd4,  32'h80000000,  32'd4,         K_SINGLE, 12'h010, 32'h08000000,  32'h0));
        vecs.push_back(mk("SHL",   4'd5,  32'd1,         32'd31,        K_SINGLE, 12'h020, 32'h80000000,  32'h0));
        vecs.push_back(mk("ROR",   4'd6,  32'd1,         32'd1,         K_SINGLE, 12'h040, 32'h80000000,  32'h0));
        vecs.push_back(mk("AND",   4'd8,  32'hF0F0F0F0,  32'hFF00FF00,  K_SINGLE, 12'h100, 32'hF000F000,  32'h0));
        vecs.push_back(mk("OR",    4'd9,  32'hF0F0F0F0,  32'h0F0F0000,  K_SINGLE, 12'h200, 32'hFFFFF0F0,  32'h0));
        vecs.push_back(mk("NEG",   4'd10, 32'd5,         32'd0,         K_SINGLE, 12'h400, 32'hFFFFFFFB,  32'h0));
        vecs.push_back(mk("NOT",   4'd11, 32'h12345678,  32'd0,         K_SINGLE, 12'h800, 32'hEDCBA987,  32'h0));
        vecs.push_back(mk("MULBIG",4'd2,  32'h00010000,  32'h00010000,  K_MULDIV, 12'h004, 32'h0,         32'h1));
        vecs.push_back(mk("ILL15", 4'd15, 32'd1,         32'd1,         K_ILL,    12'h000, 32'h0,         32'h0));
        vecs.push_back(mk("ILL12", 4'd12, 32'd1,         32'd1,         K_ILL,    12'h000, 32'h0,         32'h0));

        repeat (2) @(negedge clk);
        bus.start = 1'b1; bus.op = 4'd0; bus.a_in = 32'd3; bus.b_in = 32'd4;
        @(negedge clk);
        check("reset outputs", 256'(all_outs()), 256'(0));
        bus.start = 1'b0;
        clr = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // DIV 15/-5 with start held; operands switch to SUB 15,5 mid-request.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 4'd3; bus.a_in = 32'd15; bus.b_in = 32'hFFFFFFFB;
        for (int c = 1; c <= 3 + W; c++) begin
            @(negedge clk);
            if (c == 1) begin bus.op = 4'd1; bus.a_in = 32'd15; bus.b_in = 32'd5; end
            check($sformatf("held DIV c%0d flags", c), 256'(act_flags()), 256'(exp_flags(K_MULDIV, c, 12'h008)));
            if (c == 2 + W) check("held DIV z_lo", 256'(bus.z_lo), 256'(32'hFFFFFFFD));
            if (c == 3 + W) check("held DIV z_hi", 256'(bus.z_hi), 256'(32'h0));
        end
        @(negedge clk);
        check("held accept cycle idle", 256'(act_flags()), 256'(18'h0));
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            check($sformatf("held SUB c%0d flags", c), 256'(act_flags()), 256'(exp_flags(K_SINGLE, c, 12'h002)));
            if (c == 2) check("held SUB rz_out", 256'(bus.rz_out), 256'(32'd10));
        end
        @(negedge clk);
        check("held SUB idle after", 256'(act_flags()), 256'(18'h0));

        // MUL 15x5 cleared during its third cycle.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 4'd2; bus.a_in = 32'd15; bus.b_in = 32'd5;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            check($sformatf("clr MUL c%0d flags", c), 256'(act_flags()), 256'(exp_flags(K_MULDIV, c, 12'h004)));
        end
        clr = 1'b1;
        #1;
        check("clr async outputs", 256'(all_outs()), 256'(0));
        @(negedge clk);
        clr = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("post clr idle %0d", c), 256'(act_flags()), 256'(18'h0));
        end
        last_lo = '0;
        last_hi = '0;
        run_vec(vecs[0]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle execution sequencer that sits directly upstream of the 32-bit `alu` in the bus-architecture datapath. It accepts an operation and two operands from control, drives the ALU's one-hot control vector and X/Y operands, and allows extra settle cycles for MUL/DIV. It captures the 64-bit ALU result into an internal Z register and sequences writeback: Rz for single-word ops, LO then HI for MUL/DIV.

## Interface
- `BITS`, 32, operand width; result width is 2*BITS.
- `SIG_COUNT`, 12, width of the ALU one-hot control vector.
- `MULDIV_WAIT`, 2, extra EXEC cycles held for MUL/DIV (0 is legal).

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `clr`  in  1  reset, asynchronous and active-high.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  4  encoded op: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 SHR, 5 SHL, 6 ROR, 7 ROL, 8 AND, 9 OR, 10 NEG, 11 NOT; 12–15 illegal.
- `a_in`  in  BITS  X operand.
- `b_in`  in  BITS  Y operand.
- `alu_result`  in  2*BITS  combinational result from `alu`.
- `alu_ctrl`  out  SIG_COUNT  one-hot ALU control; bit n = op n.
- `alu_x`, `alu_y`  out  BITS  registered operands to the ALU.
- `z_hi`, `z_lo`  out  BITS  halves of the captured Z register.
- `rz_out`  out  BITS  writeback data; always equals `z_lo`.
- `rz_we`, `lo_we`, `hi_we`  out  1  writeback strobes.
- `busy`  out  1  high while a request is in progress.
- `done`  out  1  single-cycle completion pulse.
- `err`  out  1  single-cycle pulse for an illegal op.

## Operation
- States: IDLE, EXEC, WB_LO, WB_HI, ERR.
- IDLE:
  - When `start`=1, latch `a_in`→X reg, `b_in`→Y reg and `op`→op reg.
  - Go to ERR if `op`≥12, otherwise to EXEC.
  - `start`=0 holds IDLE.
- EXEC:
  - `alu_ctrl` = one-hot of the op reg.
  - Lasts 1 cycle, or 1+`MULDIV_WAIT` cycles for MUL/DIV, counted by an internal wait counter.
  - On the final EXEC edge, Z reg ← `alu_result`, then go to WB_LO.
- WB_LO:
  - Single-word op: `rz_we`=1, `done`=1, then IDLE.
  - MUL/DIV: `lo_we`=1, then WB_HI.
- WB_HI (MUL/DIV only): `hi_we`=1, `done`=1, then IDLE.
- ERR: `err`=1, `done`=1, `busy`=1, no write strobes, `alu_ctrl`=0, then IDLE.
- Outside EXEC, `alu_ctrl` is all zero. At most one write strobe is high in any cycle.
- The sequencer does not interpret results. The ALU places product/quotient in the low half and product-high/remainder in the high half. Z is forwarded unmodified.
- `z_hi`/`z_lo` hold the last captured value until the next capture.
- `start` is ignored while `busy`=1, including the `done` cycle. A `start` held high is accepted in the first IDLE cycle after `done`.

## Timing
- Cycle 0 is the cycle in which `start`=1 is sampled in IDLE.
- Single-word op:
  - Cycle 1: EXEC.
  - Cycle 2: `rz_we`=1 and `done`=1.
- MUL/DIV:
  - Cycles 1..1+W: EXEC, where W=`MULDIV_WAIT`.
  - Cycle 2+W: `lo_we`=1.
  - Cycle 3+W: `hi_we`=1 and `done`=1. With the default W=2 this is cycle 5.
- Illegal op: cycle 1 has `err`=`done`=`busy`=1.
- `busy`=1 from cycle 1 through the `done` cycle inclusive; 0 in IDLE.
- Reset value of every output is 0: all strobes, `busy`, `done`, `err`, `alu_ctrl`, `alu_x`, `alu_y`, `z_hi`, `z_lo`, `rz_out`. All registers clear and state goes to IDLE.
- `clr` asserted mid-operation:
  - Strobes drop immediately, asynchronously; no partial writeback occurs afterwards.
  - After `clr` falls, the first `start` is accepted normally.

## Test plan
- ADD, a=15, b=5 -> `alu_ctrl`=12'h001 in cycle 1; cycle 2 `rz_we`=1, `rz_out`=20, `done`=1; `busy` high for cycles 1–2 only.
- MUL, a=-15, b=5, W=2 -> `alu_ctrl`=12'h004 for cycles 1–3; cycle 4 `lo_we`=1, `z_lo`=32'hFFFFFFB5; cycle 5 `hi_we`=1, `z_hi`=32'hFFFFFFFF, `done`=1.
- ROL, a=32'h80000000, b=2 -> cycle 2 `rz_out`=32'h00000002, `rz_we`=1; `lo_we`=`hi_we`=0 throughout.
- op=13 -> cycle 1 `err`=`done`=`busy`=1; no write strobe and `alu_ctrl`=0 in every cycle; Z unchanged.
- DIV, a=15, b=-5 with `start` held high and operands changed to SUB 15,5 during the request -> DIV completes (`z_lo`=32'hFFFFFFFD, `z_hi`=0); SUB is accepted in the cycle after `done` and gives `rz_out`=10.
- MUL 15×5 with `clr` pulsed in cycle 3 -> all outputs 0 at once, no `lo_we`/`hi_we` afterwards, state IDLE; a following ADD 15+5 completes normally with `rz_out`=20.
